// File: rtl/data_mem_arbiter_if.sv
// Bus bundle for the two-port data-memory arbiter: two requester ports,
// the 32-bit-beat data-memory side, and status/debug outputs.
interface data_mem_arbiter_if;
    // Handshake: a requester raises req (with we/addr/wdata stable) and holds it
    // until it sees its one-cycle gnt pulse; the arbiter samples req only while
    // idle and answers with a one-cycle done pulse, rdata valid in that cycle.
    logic        a_req;
    logic        a_we;
    logic [9:0]  a_addr;
    logic [63:0] a_wdata;
    logic        a_gnt;
    logic        a_done;
    logic [63:0] a_rdata;

    logic        b_req;
    logic        b_we;
    logic [9:0]  b_addr;
    logic [63:0] b_wdata;
    logic        b_gnt;
    logic        b_done;
    logic [63:0] b_rdata;

    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_rdata;

    logic        busy;
    logic [1:0]  dbg_state;

    // Arbiter side
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_rdata,
        output a_gnt, a_done, a_rdata,
        output b_gnt, b_done, b_rdata,
        output mem_addr, mem_wdata, mem_read, mem_write,
        output busy, dbg_state
    );

    // Requester / memory-model side
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_rdata,
        input  a_gnt, a_done, a_rdata,
        input  b_gnt, b_done, b_rdata,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        input  busy, dbg_state
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter onto a 32-bit data memory. Each 64-bit access is split
// into two big-endian beats: LO (addr, high word) then HI (addr+4, low word).
module data_mem_arbiter #(
    parameter bit PRIO_A = 1'b0   // 1: A wins ties; 0: round-robin on ties
) (
    input  logic              clk,
    input  logic              rst,
    data_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_owner_b;    // current owner: 0 = A, 1 = B
    logic        r_prefer_b;   // tie-break favours B when set
    logic        r_we;
    logic [9:0]  r_addr;
    logic [63:0] r_wdata;
    logic [31:0] r_rd_hi;      // high read word captured at end of LO
    logic [63:0] r_a_rdata;
    logic [63:0] r_b_rdata;
    logic        w_any_req;
    logic        w_pick_b;
    logic [9:0]  w_hi_addr;

    assign w_any_req = bus.a_req | bus.b_req;
    assign w_hi_addr = r_addr + 10'd4;   // wraps modulo 1024

    // Arbitration: lone requester wins; ties go to A or the round-robin pick
    always_comb begin
        w_pick_b = 1'b0;
        if (bus.b_req && !bus.a_req) begin
            w_pick_b = 1'b1;
        end else if (bus.a_req && bus.b_req) begin
            w_pick_b = PRIO_A ? 1'b0 : r_prefer_b;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic: fixed one-cycle LO, HI and RESP phases
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next = S_LO;
            S_LO:    w_next = S_HI;
            S_HI:    w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Transaction latch, read capture and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner_b  <= 1'b0;
            r_prefer_b <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd_hi    <= '0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner_b <= w_pick_b;
                        r_we      <= w_pick_b ? bus.b_we    : bus.a_we;
                        r_addr    <= w_pick_b ? bus.b_addr  : bus.a_addr;
                        r_wdata   <= w_pick_b ? bus.b_wdata : bus.a_wdata;
                    end
                end
                S_LO: begin
                    r_rd_hi <= bus.mem_rdata[31:0];
                end
                S_HI: begin
                    // Port rdata only changes as RESP begins, so it holds until done
                    if (r_owner_b) r_b_rdata <= r_we ? 64'h0 : {r_rd_hi, bus.mem_rdata[31:0]};
                    else           r_a_rdata <= r_we ? 64'h0 : {r_rd_hi, bus.mem_rdata[31:0]};
                end
                S_RESP: begin
                    r_prefer_b <= ~r_owner_b;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; reset forces IDLE so all strobes drop at once
    always_comb begin
        bus.a_gnt     = 1'b0;
        bus.b_gnt     = 1'b0;
        bus.a_done    = 1'b0;
        bus.b_done    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.busy      = (r_state != S_IDLE);
        case (r_state)
            S_LO: begin
                bus.a_gnt     = ~r_owner_b;
                bus.b_gnt     = r_owner_b;
                bus.mem_addr  = r_addr;
                bus.mem_wdata = {32'h0, r_wdata[63:32]};
                bus.mem_write = r_we;
                bus.mem_read  = ~r_we;
            end
            S_HI: begin
                bus.mem_addr  = w_hi_addr;
                bus.mem_wdata = {32'h0, r_wdata[31:0]};
                bus.mem_write = r_we;
                bus.mem_read  = ~r_we;
            end
            S_RESP: begin
                bus.a_done = ~r_owner_b;
                bus.b_done = r_owner_b;
            end
            default: ;
        endcase
    end

    assign bus.a_rdata   = r_a_rdata;
    assign bus.b_rdata   = r_b_rdata;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed transactions, scoreboard queues for
// grants, memory beats and read data, plus a PRIO_A=1 instance for ties.
module tb_data_mem_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_arbiter_if bus0();
    data_mem_arbiter_if bus1();

    data_mem_arbiter #(.PRIO_A(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    data_mem_arbiter #(.PRIO_A(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    // Word-per-address memory model; upper half of rdata carries junk
    logic [31:0] mem [0:1023];
    always @(posedge clk) if (bus0.mem_write) mem[bus0.mem_addr] <= bus0.mem_wdata[31:0];
    assign bus0.mem_rdata = {32'hDEADBEEF, mem[bus0.mem_addr]};
    assign bus1.mem_rdata = 64'h0;

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [0:0]  exp_gnt_q[$];
    logic [74:0] exp_beat_q[$];
    logic [63:0] exp_a_q[$];
    logic [63:0] exp_b_q[$];
    logic        spacing_en = 1'b0;
    logic        have_last = 1'b0;
    int          last_gnt = 0;
    logic [0:0]  g;

    task automatic check(input string name, input logic [74:0] act, input logic [74:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [74:0] beat(input logic we, input logic [9:0] addr, input logic [31:0] w);
        return {we, addr, 32'h0, w};
    endfunction

    // Monitor: grants, memory beats and completions
    always @(negedge clk) begin
        if (!rst) begin
            if (bus0.a_gnt || bus0.b_gnt) begin
                check("gnt_onehot", {74'h0, bus0.a_gnt & bus0.b_gnt}, 75'h0);
                if (exp_gnt_q.size() == 0) begin
                    check("gnt_unexpected", {73'h0, bus0.a_gnt, bus0.b_gnt}, 75'h0);
                end else begin
                    g = exp_gnt_q.pop_front();
                    check("gnt_port", {74'h0, bus0.b_gnt}, {74'h0, g});
                end
                if (spacing_en) begin
                    if (have_last) check("gnt_spacing", 75'(cyc - last_gnt), 75'd4);
                    have_last = 1'b1;
                    last_gnt  = cyc;
                end
            end
            if (!spacing_en) have_last = 1'b0;

            if (bus0.mem_read || bus0.mem_write) begin
                check("strobe_exclusive", {74'h0, bus0.mem_read & bus0.mem_write}, 75'h0);
                if (exp_beat_q.size() == 0)
                    check("beat_unexpected", {bus0.mem_write, bus0.mem_addr, bus0.mem_wdata}, 75'h0);
                else
                    check("beat", {bus0.mem_write, bus0.mem_addr, bus0.mem_wdata}, exp_beat_q.pop_front());
            end

            if (bus0.a_done) begin
                check("done_exclusive_a", {74'h0, bus0.b_done}, 75'h0);
                if (exp_a_q.size() == 0) check("a_done_unexpected", 75'h1, 75'h0);
                else check("a_rdata", {11'h0, bus0.a_rdata}, {11'h0, exp_a_q.pop_front()});
            end
            if (bus0.b_done) begin
                check("done_exclusive_b", {74'h0, bus0.a_done}, 75'h0);
                if (exp_b_q.size() == 0) check("b_done_unexpected", 75'h1, 75'h0);
                else check("b_rdata", {11'h0, bus0.b_rdata}, {11'h0, exp_b_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 10 && !idle; i++) begin
            @(negedge clk);
            idle = !bus0.busy;
        end
        if (!idle) check("idle_timeout", 75'h0, 75'h1);
    endtask

    task automatic do_txn(input logic port_b, input logic we, input logic [9:0] addr,
                          input logic [63:0] wdata, input logic [63:0] exp_rdata);
        logic got;
        exp_gnt_q.push_back(port_b);
        exp_beat_q.push_back(beat(we, addr, wdata[63:32]));
        exp_beat_q.push_back(beat(we, addr + 10'd4, wdata[31:0]));
        if (port_b) exp_b_q.push_back(exp_rdata);
        else        exp_a_q.push_back(exp_rdata);
        @(negedge clk);
        if (port_b) begin
            bus0.b_req = 1'b1; bus0.b_we = we; bus0.b_addr = addr; bus0.b_wdata = wdata;
        end else begin
            bus0.a_req = 1'b1; bus0.a_we = we; bus0.a_addr = addr; bus0.a_wdata = wdata;
        end
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = port_b ? bus0.b_gnt : bus0.a_gnt;
        end
        if (!got) check("gnt_timeout", 75'h0, 75'h1);
        bus0.a_req = 1'b0;
        bus0.b_req = 1'b0;
        @(negedge clk);
        check("busy_in_hi", {74'h0, bus0.busy}, 75'h1);
        wait_idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #400000;
        $display("FAIL global_timeout: sim time %0t exceeded", $time);
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        bus0.a_req = 0; bus0.a_we = 0; bus0.a_addr = 0; bus0.a_wdata = 0;
        bus0.b_req = 0; bus0.b_we = 0; bus0.b_addr = 0; bus0.b_wdata = 0;
        bus1.a_req = 0; bus1.a_we = 0; bus1.a_addr = 0; bus1.a_wdata = 0;
        bus1.b_req = 0; bus1.b_we = 0; bus1.b_addr = 0; bus1.b_wdata = 0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_ctrl", {68'h0, bus0.busy, bus0.a_gnt, bus0.b_gnt, bus0.a_done,
                           bus0.b_done, bus0.mem_read, bus0.mem_write}, 75'h0);
        check("rst_mem_addr", {65'h0, bus0.mem_addr}, 75'h0);
        check("rst_mem_wdata", {11'h0, bus0.mem_wdata}, 75'h0);
        check("rst_a_rdata", {11'h0, bus0.a_rdata}, 75'h0);
        check("rst_b_rdata", {11'h0, bus0.b_rdata}, 75'h0);
        check("rst_state", {73'h0, bus0.dbg_state}, 75'h0);
        rst = 1'b0;

        // Write then read on A
        do_txn(1'b0, 1'b1, 10'h010, 64'h1122334455667788, 64'h0);
        do_txn(1'b0, 1'b0, 10'h010, 64'h0, 64'h1122334455667788);

        // Wrap: B write then read at 0x3FE (HI beat at 0x002)
        do_txn(1'b1, 1'b1, 10'h3FE, 64'hCAFEF00D0BADBEEF, 64'h0);
        do_txn(1'b1, 1'b0, 10'h3FE, 64'h0, 64'hCAFEF00D0BADBEEF);
        check("wrap_mem_hi_word", {43'h0, mem[10'h3FE]}, 75'hCAFEF00D);
        check("wrap_mem_lo_word", {43'h0, mem[10'h002]}, 75'h0BADBEEF);

        // Round-robin tie: both read continuously, expect A,B,A,B every 4 cycles
        for (int k = 0; k < 2; k++) begin
            exp_gnt_q.push_back(1'b0);
            exp_gnt_q.push_back(1'b1);
            exp_beat_q.push_back(beat(1'b0, 10'h010, 32'h0));
            exp_beat_q.push_back(beat(1'b0, 10'h014, 32'h0));
            exp_beat_q.push_back(beat(1'b0, 10'h3FE, 32'h0));
            exp_beat_q.push_back(beat(1'b0, 10'h002, 32'h0));
            exp_a_q.push_back(64'h1122334455667788);
            exp_b_q.push_back(64'hCAFEF00D0BADBEEF);
        end
        @(negedge clk);
        spacing_en = 1'b1;
        bus0.a_req = 1; bus0.a_we = 0; bus0.a_addr = 10'h010; bus0.a_wdata = 0;
        bus0.b_req = 1; bus0.b_we = 0; bus0.b_addr = 10'h3FE; bus0.b_wdata = 0;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (bus0.a_gnt || bus0.b_gnt) n++;
        end
        if (n < 4) check("tie_gnt_timeout", 75'(n), 75'd4);
        bus0.a_req = 0;
        bus0.b_req = 0;
        wait_idle();
        spacing_en = 1'b0;

        // B pulses req during an A transaction: ignored, no B grant or strobes
        exp_gnt_q.push_back(1'b0);
        exp_beat_q.push_back(beat(1'b0, 10'h010, 32'h0));
        exp_beat_q.push_back(beat(1'b0, 10'h014, 32'h0));
        exp_a_q.push_back(64'h1122334455667788);
        @(negedge clk);
        bus0.a_req = 1; bus0.a_we = 0; bus0.a_addr = 10'h010; bus0.a_wdata = 0;
        n = 0;
        for (int i = 0; i < 10 && n == 0; i++) begin
            @(negedge clk);
            if (bus0.a_gnt) n = 1;
        end
        if (n == 0) check("ignore_gnt_timeout", 75'h0, 75'h1);
        bus0.a_req = 0;
        bus0.b_req = 1; bus0.b_we = 1; bus0.b_addr = 10'h020; bus0.b_wdata = 64'h5;
        @(negedge clk);
        bus0.b_req = 0;
        wait_idle();
        repeat (3) @(negedge clk);

        // rdata holds between a port's completions
        check("hold_a_rdata", {11'h0, bus0.a_rdata}, {11'h0, 64'h1122334455667788});
        check("hold_b_rdata", {11'h0, bus0.b_rdata}, {11'h0, 64'hCAFEF00D0BADBEEF});

        // PRIO_A=1 instance: A wins every tie
        @(negedge clk);
        bus1.a_req = 1; bus1.b_req = 1;
        n = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(negedge clk);
            if (bus1.a_gnt || bus1.b_gnt) begin
                n++;
                check("prio_a_wins", {73'h0, bus1.a_gnt, bus1.b_gnt}, 75'h2);
            end
        end
        if (n < 3) check("prio_gnt_timeout", 75'(n), 75'd3);
        bus1.a_req = 0; bus1.b_req = 0;
        repeat (4) @(negedge clk);

        // Reset during HI beat of a write
        do_txn(1'b0, 1'b1, 10'h100, 64'h1111111122222222, 64'h0);
        exp_gnt_q.push_back(1'b0);
        exp_beat_q.push_back(beat(1'b1, 10'h100, 32'hAAAAAAAA));
        @(negedge clk);
        bus0.a_req = 1; bus0.a_we = 1; bus0.a_addr = 10'h100; bus0.a_wdata = 64'hAAAAAAAABBBBBBBB;
        n = 0;
        for (int i = 0; i < 10 && n == 0; i++) begin
            @(negedge clk);
            if (bus0.a_gnt) n = 1;
        end
        if (n == 0) check("abort_gnt_timeout", 75'h0, 75'h1);
        bus0.a_req = 0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_strobes", {72'h0, bus0.mem_write, bus0.mem_read, bus0.busy}, 75'h0);
        check("abort_no_done", {73'h0, bus0.a_done, bus0.b_done}, 75'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_mem_hi_word", {43'h0, mem[10'h100]}, 75'hAAAAAAAA);
        check("abort_mem_lo_word", {43'h0, mem[10'h104]}, 75'h22222222);
        check("abort_rdata_cleared", {11'h0, bus0.a_rdata}, 75'h0);
        do_txn(1'b0, 1'b0, 10'h100, 64'h0, 64'hAAAAAAAA22222222);

        // Every expectation consumed
        check("gnt_q_empty", 75'(exp_gnt_q.size()), 75'h0);
        check("beat_q_empty", 75'(exp_beat_q.size()), 75'h0);
        check("a_q_empty", 75'(exp_a_q.size()), 75'h0);
        check("b_q_empty", 75'(exp_b_q.size()), 75'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter PRIO_A, default 0: 1 = port A always wins a tie; 0 = round-robin on a tie.
REQ-002 SHALL have port clk  in  1  system clock; all state changes on posedge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports a_req in 1, a_we in 1, a_addr in 10, a_wdata in 64: port A request, write-enable, byte address, write data.
REQ-005 SHALL have ports a_gnt out 1, a_done out 1, a_rdata out 64: port A grant pulse, completion pulse, read data.
REQ-006 SHALL have ports b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_rdata with the same widths and meanings as the port A set.
REQ-007 SHALL have ports mem_addr out 10, mem_wdata out 64, mem_read out 1, mem_write out 1: the data-memory address, write data and strobes.
REQ-008 SHALL have port mem_rdata  in  64  data-memory read data; only bits [31:0] are used.
REQ-009 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-010 SHALL implement the FSM IDLE -> LO -> HI -> RESP -> IDLE, with exactly one cycle in each of LO, HI and RESP.
REQ-011 In IDLE with any req sampled high, SHALL choose an owner, latch its we, addr and wdata, pulse the owner's gnt for the next cycle (the LO cycle), and go to LO.
REQ-012 Arbitration: a single requester wins; on a tie, PRIO_A=1 gives A, and PRIO_A=0 gives the port not granted last. The round-robin pointer updates on leaving RESP.
REQ-013 Requests SHALL be sampled only in IDLE; req during busy is ignored and not queued; the requester holds req until gnt.
REQ-014 Each 64-bit access SHALL be split into two big-endian 32-bit beats.
REQ-015 LO beat SHALL drive mem_addr=addr and mem_wdata[31:0]=wdata[63:32].
REQ-016 HI beat SHALL drive mem_addr=(addr+4) mod 1024 and mem_wdata[31:0]=wdata[31:0].
REQ-017 mem_wdata[63:32] SHALL always be 0.
REQ-018 During LO and HI, mem_write SHALL equal the latched we and mem_read SHALL equal its inverse; both SHALL be 0 in IDLE and RESP, and never both 1.
REQ-019 On a read, mem_rdata[31:0] SHALL be captured into rdata[63:32] at the edge ending LO, and into rdata[31:0] at the edge ending HI.
REQ-020 In RESP the owner's done SHALL be high for exactly one cycle, with its rdata valid; the non-owner's done SHALL stay 0.
REQ-021 After a write, the owner's rdata SHALL be 0.
REQ-022 Each port's rdata SHALL hold its value until that port's next done.
REQ-023 Latency SHALL be: gnt 1 cycle after the req-sampling edge, done 2 cycles after gnt; back-to-back transactions start every 4 cycles minimum.
REQ-024 Unaligned addresses SHALL pass through unchanged; the addr+4 computation wraps modulo 1024 (e.g. 0x3FE -> 0x002).

Reset
REQ-025 While rst is high, the block SHALL asynchronously force: state IDLE; busy, gnt, done, mem_read and mem_write 0; mem_addr and mem_wdata 0; both rdata 0; round-robin pointer favouring A.
REQ-026 Reset mid-transaction SHALL abort with no done; a completed LO write beat is not rolled back; after rst falls, the first edge samples requests normally.

Verification
REQ-027 Write then read on A: write, addr 0x010, wdata 0x1122334455667788 -> LO mem_addr 0x010, mem_wdata 0x11223344; HI mem_addr 0x014, mem_wdata 0x55667788; read of 0x010 -> a_rdata 0x1122334455667788 with a_done.
REQ-028 Tie, PRIO_A=0, both requesting reads continuously from reset -> grants in order A, B, A, B with exactly 4 cycles between consecutive gnt pulses.
REQ-029 Tie, PRIO_A=1 -> A granted every time; B never granted while A holds req.
REQ-030 Wrap: read at addr 0x3FE -> HI beat mem_addr 0x002; b_rdata assembled from 0x3FE (high word) and 0x002 (low word).
REQ-031 b_req pulsed during an A transaction and dropped before IDLE -> no B grant; B issues no memory strobes.
REQ-032 rst asserted during the HI beat of a write -> mem_write 0 immediately, no done, busy 0; only the high word at addr is updated in memory.
